// File: rtl/tap_controller_if.sv
// rtl/tap_controller_if.sv - TAP controller mode-select input and state-decode strobes (StateOut present when TAP_STATE_DEBUG_EN is defined)
interface tap_controller_if;
  logic       TMS;
  logic       CaptureDR;
  logic       ShiftDR;
  logic       UpdateDR;
  logic       ClockDR;
  logic       CaptureIR;
  logic       ShiftIR;
  logic       UpdateIR;
  logic       ClockIR;
  logic       Select;
  logic       Enable;
  logic       TestReset;
`ifdef TAP_STATE_DEBUG_EN
  logic [3:0] StateOut;
`endif

  // Test-access side: drives TMS, observes the decoded strobes
  modport master (
`ifdef TAP_STATE_DEBUG_EN
    input  StateOut,
`endif
    output TMS,
    input  CaptureDR, ShiftDR, UpdateDR, ClockDR,
    input  CaptureIR, ShiftIR, UpdateIR, ClockIR,
    input  Select, Enable, TestReset
  );

  // Controller side
  modport slave (
`ifdef TAP_STATE_DEBUG_EN
    output StateOut,
`endif
    input  TMS,
    output CaptureDR, ShiftDR, UpdateDR, ClockDR,
    output CaptureIR, ShiftIR, UpdateIR, ClockIR,
    output Select, Enable, TestReset
  );
endinterface

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1 TAP state machine with Moore-decoded strobes; TAP_STATE_DEBUG_EN adds StateOut
module tap_controller (
  input  logic             TCK,
  input  logic             Reset,
  tap_controller_if.slave  tap
);

  typedef enum logic [3:0] {
    S_EX2_DR = 4'h0,
    S_EX1_DR = 4'h1,
    S_SH_DR  = 4'h2,
    S_PAU_DR = 4'h3,
    S_SEL_IR = 4'h4,
    S_UPD_DR = 4'h5,
    S_CAP_DR = 4'h6,
    S_SEL_DR = 4'h7,
    S_EX2_IR = 4'h8,
    S_EX1_IR = 4'h9,
    S_SH_IR  = 4'hA,
    S_PAU_IR = 4'hB,
    S_RTI    = 4'hC,
    S_UPD_IR = 4'hD,
    S_CAP_IR = 4'hE,
    S_TLR    = 4'hF
  } tap_state_t;

  tap_state_t state;
  tap_state_t next_state;

  // State register; reset wins over any TMS-driven move, even mid-shift
  always_ff @(posedge TCK) begin
    if (Reset) state <= S_TLR;
    else       state <= next_state;
  end

  // Next-state: standard TAP graph, any upset encoding falls back to TLR
  always_comb begin
    next_state = S_TLR;
    case (state)
      S_TLR:    next_state = tap.TMS ? S_TLR    : S_RTI;
      S_RTI:    next_state = tap.TMS ? S_SEL_DR : S_RTI;
      S_SEL_DR: next_state = tap.TMS ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: next_state = tap.TMS ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  next_state = tap.TMS ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: next_state = tap.TMS ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: next_state = tap.TMS ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: next_state = tap.TMS ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: next_state = tap.TMS ? S_SEL_DR : S_RTI;
      S_SEL_IR: next_state = tap.TMS ? S_TLR    : S_CAP_IR;
      S_CAP_IR: next_state = tap.TMS ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  next_state = tap.TMS ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: next_state = tap.TMS ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: next_state = tap.TMS ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: next_state = tap.TMS ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: next_state = tap.TMS ? S_SEL_DR : S_RTI;
      default:  next_state = S_TLR;
    endcase
  end

  // Output decode from the state register only, so TMS never reaches a strobe
  always_comb begin
    tap.CaptureDR = (state == S_CAP_DR);
    tap.ShiftDR   = (state == S_SH_DR);
    tap.UpdateDR  = (state == S_UPD_DR);
    tap.ClockDR   = (state == S_CAP_DR) || (state == S_SH_DR);
    tap.CaptureIR = (state == S_CAP_IR);
    tap.ShiftIR   = (state == S_SH_IR);
    tap.UpdateIR  = (state == S_UPD_IR);
    tap.ClockIR   = (state == S_CAP_IR) || (state == S_SH_IR);
    tap.Select    = (state == S_SEL_IR) || (state == S_CAP_IR) ||
                    (state == S_SH_IR)  || (state == S_EX1_IR) ||
                    (state == S_PAU_IR) || (state == S_EX2_IR) ||
                    (state == S_UPD_IR);
    tap.Enable    = (state == S_SH_DR) || (state == S_SH_IR);
    tap.TestReset = (state == S_TLR);
  end

`ifdef TAP_STATE_DEBUG_EN
  assign tap.StateOut = state;
`else
  // No state observation port in this build
`endif

endmodule
